// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg
// Brief    : Parametrised universal shift register with serial word counter.
// Revision : 1.0
// ============================================================================
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CW-1:0]    bit_cnt,
    output logic             word_valid
);

    localparam logic [2:0] c_MODE_HOLD = 3'b000;
    localparam logic [2:0] c_MODE_SHL  = 3'b001;
    localparam logic [2:0] c_MODE_SHR  = 3'b010;
    localparam logic [2:0] c_MODE_ROL  = 3'b011;
    localparam logic [2:0] c_MODE_ROR  = 3'b100;
    localparam logic [2:0] c_MODE_LOAD = 3'b101;
    localparam logic [2:0] c_MODE_CLR  = 3'b110;
    localparam logic [2:0] c_MODE_ASR  = 3'b111;

    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_wv;

    logic [WIDTH-1:0] w_q_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_wv_nxt;
    logic             w_serial;

    always_comb begin
        w_q_nxt = r_q;
        case (mode)
            c_MODE_HOLD: w_q_nxt = r_q;
            c_MODE_SHL:  w_q_nxt = {r_q[WIDTH-2:0], sin_r};
            c_MODE_SHR:  w_q_nxt = {sin_l, r_q[WIDTH-1:1]};
            c_MODE_ROL:  w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            c_MODE_ROR:  w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
            c_MODE_LOAD: w_q_nxt = pdata;
            c_MODE_CLR:  w_q_nxt = '0;
            c_MODE_ASR:  w_q_nxt = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            default:     w_q_nxt = r_q;
        endcase
    end

    // Only serial shifts advance the word; load/clear start a fresh word.
    assign w_serial = (mode == c_MODE_SHL) || (mode == c_MODE_SHR);

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_wv_nxt  = 1'b0;
        if (w_serial) begin
            if (r_cnt == c_LAST) begin
                w_cnt_nxt = '0;
                w_wv_nxt  = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end else if ((mode == c_MODE_LOAD) || (mode == c_MODE_CLR)) begin
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= RESET_VAL;
            r_cnt <= '0;
            r_wv  <= 1'b0;
        end else if (en) begin
            r_q   <= w_q_nxt;
            r_cnt <= w_cnt_nxt;
            r_wv  <= w_wv_nxt;
        end else begin
            r_wv  <= 1'b0;
        end
    end

    assign q          = r_q;
    assign sout_msb   = r_q[WIDTH-1];
    assign sout_lsb   = r_q[0];
    assign bit_cnt    = r_cnt;
    assign word_valid = r_wv;

endmodule
`default_nettype wire
